// File: rtl/nw_score_pkg.sv
// Shared types and constants for the score neighbour fetch stage.
package nw_score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int unsigned TAG_W = 2;

  localparam logic [TAG_W-1:0] SLOT_DIAG = 2'd0;
  localparam logic [TAG_W-1:0] SLOT_LEFT = 2'd1;
  localparam logic [TAG_W-1:0] SLOT_UP   = 2'd2;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line carrying {valid, slot tag} alongside the score RAM read latency.
module rd_lat_pipe
  import nw_score_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;

  // Shift tag stages; reset drops every in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      tag_q[0] <= in_tag_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/score_neighbour_fetch.sv
// Fetches diag/left/up neighbour scores for one NW cell and hands them out
// on a valid/ready port. Optional macro DIAG_REUSE_EN: reuse the previous
// up score as diag when requests walk along a row.
module score_neighbour_fetch
  import nw_score_pkg::*;
#(
  parameter int unsigned SCORE_W = 9,
  parameter int unsigned N_ROWS  = 16,
  parameter int unsigned N_COLS  = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ADDR_W  = $clog2((N_ROWS + 1) * (N_COLS + 1))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [SCORE_W-1:0] ram_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] diag,
  output logic [SCORE_W-1:0] left,
  output logic [SCORE_W-1:0] up
);

  localparam logic [ADDR_W-1:0] OFS_DIAG = ADDR_W'(N_COLS + 2);
  localparam logic [ADDR_W-1:0] OFS_UP   = ADDR_W'(N_COLS + 1);
  localparam logic [ADDR_W-1:0] OFS_LEFT = ADDR_W'(1);

  state_e             state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [TAG_W-1:0]   slot_q;
  logic               req_ready_q;
  logic               ram_rd_en_q;
  logic [ADDR_W-1:0]  ram_rd_addr_q;
  logic               out_valid_q;
  logic [SCORE_W-1:0] diag_q, left_q, up_q;
  logic [SCORE_W-1:0] diag_buf_q, left_buf_q;

  logic               pipe_vld;
  logic [TAG_W-1:0]   pipe_tag;

`ifdef DIAG_REUSE_EN
  logic               reuse_vld_q;
  logic [ADDR_W-1:0]  prev_idx_q;
  logic [SCORE_W-1:0] prev_up_q;
`endif

  // Tag of each issued read emerges exactly when its data returns
  rd_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (ram_rd_en_q),
    .in_tag_i    (slot_q),
    .out_valid_o (pipe_vld),
    .out_tag_o   (pipe_tag)
  );

  // Request/issue/drain/hold sequencing with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      slot_q        <= SLOT_DIAG;
      req_ready_q   <= 1'b1;
      ram_rd_en_q   <= 1'b0;
      ram_rd_addr_q <= '0;
      out_valid_q   <= 1'b0;
      diag_q        <= '0;
      left_q        <= '0;
      up_q          <= '0;
      diag_buf_q    <= '0;
      left_buf_q    <= '0;
`ifdef DIAG_REUSE_EN
      reuse_vld_q   <= 1'b0;
      prev_idx_q    <= '0;
      prev_up_q     <= '0;
`endif
    end else begin
      // Early slots park in buffers so delivered outputs stay untouched
      if (pipe_vld && (pipe_tag == SLOT_DIAG)) diag_buf_q <= ram_rd_data;
      if (pipe_vld && (pipe_tag == SLOT_LEFT)) left_buf_q <= ram_rd_data;

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            idx_q       <= req_addr;
            req_ready_q <= 1'b0;
            ram_rd_en_q <= 1'b1;
            state_q     <= ST_ISSUE;
`ifdef DIAG_REUSE_EN
            if (reuse_vld_q && (req_addr == prev_idx_q + ADDR_W'(1))) begin
              diag_buf_q    <= prev_up_q;
              slot_q        <= SLOT_LEFT;
              ram_rd_addr_q <= req_addr - OFS_LEFT;
            end else begin
              reuse_vld_q   <= 1'b0;
              slot_q        <= SLOT_DIAG;
              ram_rd_addr_q <= req_addr - OFS_DIAG;
            end
`else
            slot_q        <= SLOT_DIAG;
            ram_rd_addr_q <= req_addr - OFS_DIAG;
`endif
          end
        end

        ST_ISSUE: begin
          if (slot_q == SLOT_UP) begin
            ram_rd_en_q <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            slot_q <= slot_q + TAG_W'(1);
            if (slot_q == SLOT_DIAG) ram_rd_addr_q <= idx_q - OFS_LEFT;
            else                     ram_rd_addr_q <= idx_q - OFS_UP;
          end
        end

        ST_DRAIN: begin
          // Up is always the last slot back; publish the whole triple at once
          if (pipe_vld && (pipe_tag == SLOT_UP)) begin
            diag_q      <= diag_buf_q;
            left_q      <= left_buf_q;
            up_q        <= ram_rd_data;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
`ifdef DIAG_REUSE_EN
            reuse_vld_q <= 1'b1;
            prev_idx_q  <= idx_q;
            prev_up_q   <= up_q;
`endif
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign ram_rd_en   = ram_rd_en_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign out_valid   = out_valid_q;
  assign diag        = diag_q;
  assign left        = left_q;
  assign up          = up_q;

endmodule

// File: tb/tb_score_neighbour_fetch.sv
// Directed bench: RD_LAT=1 instance (a_) for most cases, RD_LAT=3 instance (b_).
module tb_score_neighbour_fetch;

  localparam int unsigned SW = 9;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_req_valid, a_req_ready, a_rd_en, a_out_valid, a_out_ready;
  logic [AW-1:0] a_req_addr, a_rd_addr;
  logic [SW-1:0] a_rd_data, a_diag, a_left, a_up;
  logic          b_req_valid, b_req_ready, b_rd_en, b_out_valid, b_out_ready;
  logic [AW-1:0] b_req_addr, b_rd_addr;
  logic [SW-1:0] b_rd_data, b_diag, b_left, b_up;

  score_neighbour_fetch #(.SCORE_W(SW), .N_ROWS(16), .N_COLS(16), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr), .ram_rd_en(a_rd_en), .ram_rd_addr(a_rd_addr),
    .ram_rd_data(a_rd_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .diag(a_diag), .left(a_left), .up(a_up));

  score_neighbour_fetch #(.SCORE_W(SW), .N_ROWS(16), .N_COLS(16), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .ram_rd_en(b_rd_en), .ram_rd_addr(b_rd_addr),
    .ram_rd_data(b_rd_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .diag(b_diag), .left(b_left), .up(b_up));

  // Score RAM models: each word holds its own address; junk when not read
  logic [SW-1:0] a_pipe [1];
  logic [SW-1:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe[0] <= a_rd_en ? SW'(a_rd_addr) : 9'h1AA;
    b_pipe[0] <= b_rd_en ? SW'(b_rd_addr) : 9'h1AA;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_rd_data = a_pipe[0];
  assign b_rd_data = b_pipe[2];

  // Read address log and handshake monitor
  int unsigned a_log[$];
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          acc_cyc[$];
  int          xfer_cyc[$];
  int unsigned xfer_d[$], xfer_l[$], xfer_u[$];
  int          rr_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (a_rd_en) a_log.push_back(int'(a_rd_addr));
    if (mon_en) begin
      if (a_req_ready) rr_cnt++;
      if (a_req_valid && a_req_ready) acc_cyc.push_back(cyc);
      if (a_out_valid && a_out_ready) begin
        xfer_cyc.push_back(cyc);
        xfer_d.push_back(int'(a_diag));
        xfer_l.push_back(int'(a_left));
        xfer_u.push_back(int'(a_up));
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance a; lat = cycle index where out_valid first seen
  task automatic a_request(input int addr, output int lat);
    int n;
    a_log.delete();
    a_req_addr  = AW'(addr);
    a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 40) begin tick(); n++; end
    tick();
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic check_triple(input string tag, input int d, input int l, input int u);
    check_eq({tag, "_diag"}, 32'(a_diag), 32'(d));
    check_eq({tag, "_left"}, 32'(a_left), 32'(l));
    check_eq({tag, "_up"},   32'(a_up),   32'(u));
  endtask

  task automatic check_reads(input string tag, input int cnt, input int r0, input int r1, input int r2);
    int exp [3];
    exp[0] = r0; exp[1] = r1; exp[2] = r2;
    check_eq({tag, "_nreads"}, 32'(a_log.size()), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      if (i < a_log.size()) check_eq({tag, "_rdaddr"}, a_log[i], 32'(exp[i]));
  endtask

  task automatic check_a_reset(input string tag);
    check_eq({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
    check_eq({tag, "_rd_en"},     32'(a_rd_en),     32'd0);
    check_eq({tag, "_rd_addr"},   32'(a_rd_addr),   32'd0);
    check_eq({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
    check_triple(tag, 0, 0, 0);
  endtask

  int lat;
  int n;
  int b2b_addr [3] = '{70, 90, 110};
  int b2b_exp  [3][3] = '{'{52, 69, 53}, '{72, 89, 73}, '{92, 109, 93}};
  logic [SW-1:0] hd, hl, hu;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_out_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_out_ready = 1'b0;
    tick(); tick();
    check_a_reset("rst");
    check_eq("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check_eq("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // idx 18 (i=1,j=1), RD_LAT=1, then stall in HOLD for 4 cycles
    a_request(18, lat);
    check_eq("t1_latency", 32'(lat), 32'd5);
    check_reads("t1", 3, 0, 17, 1);
    check_triple("t1", 0, 17, 1);
    hd = a_diag; hl = a_left; hu = a_up;
    for (int k = 0; k < 4; k++) begin
      check_eq("hold_out_valid", 32'(a_out_valid), 32'd1);
      check_eq("hold_req_ready", 32'(a_req_ready), 32'd0);
      check_eq("hold_diag", 32'(a_diag), 32'(hd));
      check_eq("hold_left", 32'(a_left), 32'(hl));
      check_eq("hold_up",   32'(a_up),   32'(hu));
      tick();
    end
    check_eq("hold_nreads", 32'(a_log.size()), 32'd3);
    a_out_ready = 1'b1;
    tick();
    check_eq("t1_post_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("t1_post_req_ready", 32'(a_req_ready), 32'd1);
    check_triple("t1_kept", 0, 17, 1);
    a_out_ready = 1'b0;

    // idx 40 on RD_LAT=3 instance
    b_req_addr  = 9'd40;
    b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 40) begin tick(); lat++; end
    check_eq("t2_latency", 32'(lat), 32'd7);
    check_eq("t2_diag", 32'(b_diag), 32'd22);
    check_eq("t2_left", 32'(b_left), 32'd39);
    check_eq("t2_up",   32'(b_up),   32'd23);
    b_out_ready = 1'b1;
    tick();
    check_eq("t2_post_out_valid", 32'(b_out_valid), 32'd0);
    b_out_ready = 1'b0;

    // Reset asserted during the second cycle of ISSUE
    a_req_addr  = 9'd52;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    check_eq("t3_issuing", 32'(a_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    check_a_reset("t3_rst");
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check_a_reset("t3_idle");
    a_request(52, lat);
    check_eq("t3_latency", 32'(lat), 32'd5);
    check_reads("t3", 3, 34, 51, 35);
    check_triple("t3", 34, 51, 35);
    a_out_ready = 1'b1;
    tick();

    // Back-to-back requests with out_ready held high
    acc_cyc.delete(); xfer_cyc.delete();
    rr_cnt = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_req_addr  = AW'(b2b_addr[k]);
      a_req_valid = 1'b1;
      n = 0;
      while (!a_req_ready && n < 40) begin tick(); n++; end
      tick();
    end
    a_req_valid = 1'b0;
    n = 0;
    while (xfer_cyc.size() < 3 && n < 40) begin tick(); n++; end
    mon_en = 1'b0;
    check_eq("b2b_n_accept", 32'(acc_cyc.size()), 32'd3);
    check_eq("b2b_n_xfer", 32'(xfer_cyc.size()), 32'd3);
    check_eq("b2b_ready_cycles", 32'(rr_cnt), 32'd3);
    if (acc_cyc.size() == 3 && xfer_cyc.size() == 3) begin
      check_eq("b2b_period01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check_eq("b2b_period12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
      for (int k = 0; k < 3; k++) begin
        check_eq("b2b_latency", 32'(xfer_cyc[k] - acc_cyc[k]), 32'd5);
        check_eq("b2b_diag", xfer_d[k], 32'(b2b_exp[k][0]));
        check_eq("b2b_left", xfer_l[k], 32'(b2b_exp[k][1]));
        check_eq("b2b_up",   xfer_u[k], 32'(b2b_exp[k][2]));
      end
    end
    a_out_ready = 1'b0;

`ifdef DIAG_REUSE_EN
    // Row walk 18 -> 19 reuses diag; 36 breaks the run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    a_request(18, lat);
    check_triple("ru18", 0, 17, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    a_request(19, lat);
    check_eq("ru19_latency", 32'(lat), 32'd4);
    check_reads("ru19", 2, 18, 2, 0);
    check_triple("ru19", 1, 18, 2);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    a_request(36, lat);
    check_eq("ru36_latency", 32'(lat), 32'd5);
    check_reads("ru36", 3, 18, 35, 19);
    check_triple("ru36", 18, 35, 19);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_neighbour_fetch.md
# score_neighbour_fetch

Parametrised fetch/buffer stage between the score RAM and the Needleman-Wunsch cell processor. For each requested cell it issues the three neighbour reads (diag, left, up) to the score RAM, compensates a configurable RAM read latency, and presents the assembled triple on a valid/ready output handshake. It supersedes the fixed 9-bit, count-driven output manager.

## Interface
- SCORE_W, 9, score width in bits (two's complement)
- N_ROWS, 16, sequence A length; matrix has N_ROWS+1 rows
- N_COLS, 16, sequence B length; matrix has N_COLS+1 columns
- RD_LAT, 1, score RAM read latency in cycles, 1..4
- ADDR_W, $clog2((N_ROWS+1)*(N_COLS+1)), linear RAM address width (derived)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  cell request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  linear index i*(N_COLS+1)+j of cell being computed
- ram_rd_en  out  1  score RAM read strobe
- ram_rd_addr  out  ADDR_W  score RAM read address
- ram_rd_data  in  SCORE_W  score RAM read data, valid RD_LAT cycles after ram_rd_en
- out_valid  out  1  neighbour triple valid
- out_ready  in  1  consumer accepts triple
- diag, left, up  out  SCORE_W each  neighbour scores

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: req_ready=1. req_valid&req_ready latches req_addr -> ISSUE.
- ISSUE: one read per cycle, order diag (idx-N_COLS-2), left (idx-1), up (idx-N_COLS-1); each read pushes its slot tag into the latency pipe. After last read -> DRAIN.
- DRAIN: returning data written to slot given by tag emerging from pipe. When final slot written -> HOLD.
- HOLD: out_valid=1; outputs stable. out_valid&out_ready -> IDLE.
- Requests with i==0 or j==0 are out of contract (boundary cells handled upstream); no check performed.
- Address arithmetic in ADDR_W bits; no wrap for in-contract requests.
- diag/left/up hold last delivered triple between transactions (not zeroed).

## Timing
- Reset values: req_ready=1 (IDLE), ram_rd_en=0, ram_rd_addr=0, out_valid=0, diag=left=up=0.
- Request accepted cycle 0; reads on cycles 1,2,3; last data sampled cycle 3+RD_LAT; out_valid rises cycle 4+RD_LAT.
- out_ready may be high before out_valid; transfer completes first cycle both high; req_ready high the following cycle.
- Back-to-back throughput: one triple per 5+RD_LAT cycles (4+RD_LAT with reuse hit).
- Reset mid-operation: FSM to IDLE, latency pipe flushed, in-flight RAM data discarded, reuse state cleared.
- ram_rd_data sampled only when a tag emerges; other cycles ignored.

## Configuration
- DIAG_REUSE_EN defined: block keeps last delivered up value and address. If new req_addr == previous req_addr+1, diag is taken from saved up and only left and up are read (cycles 1,2). Reuse invalidated by reset or any non-consecutive request.
- Undefined: three reads every request; no reuse registers.

## Structure
- Package nw_score_pkg: FSM state enum, slot constants SLOT_DIAG=0, SLOT_LEFT=1, SLOT_UP=2, tag width.
- Sub-module rd_lat_pipe: RD_LAT-deep shift register of {valid, slot tag}, async reset clears all valid bits.

## Test plan
- RD_LAT=1, N_COLS=16, RAM preloaded with addr value; request idx 18 (i=1,j=1) -> reads 0,17,1; out_valid cycle 5 with diag=0, left=17, up=1.
- RD_LAT=3, request idx 40 -> out_valid cycle 7, diag=22, left=39, up=23.
- out_ready low 4 cycles in HOLD -> outputs stable, req_ready=0 throughout; no extra reads.
- rst pulse on cycle 2 of ISSUE -> all outputs to reset values; next request returns correct triple, no stale data.
- DIAG_REUSE_EN: requests 18 then 19 -> second issues only reads 18,2; diag=1; then request 36 -> three reads again.
- Back-to-back requests with out_ready held high -> one triple per 5+RD_LAT cycles, req_ready pattern matches.
